demux_1x2_8bit_stream: RTL
==========================

Name: demux_1x2_8bit_stream

Overview:
Registered 1-to-2 demultiplexer: the steering counterpart of the 8-bit 2:1 mux in the datapath.
- Accepts one 8-bit word per cycle on a valid/ready input channel.
- Routes each word by `sel` to one of two valid/ready output channels.
- Each output has a small FIFO, so one stalled consumer does not block traffic already queued for the other.
- Used where a single producer (e.g. writeback/forwarding bus) feeds two consumers with independent backpressure.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- inp  input  WIDTH  input data word.
- inp_valid  input  1  inp/sel qualified this cycle.
- inp_ready  output  1  block accepts inp this cycle.
- sel  input  1  destination: 0 -> out1, 1 -> out2; sampled only on accept.
- out1  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes out1 this cycle.
- out2  output  WIDTH  head word of FIFO 2.
- out2_valid  output  1  FIFO 2 non-empty.
- out2_ready  input  1  consumer 2 takes out2 this cycle.
- count1  output  log2(DEPTH)+1  occupancy of FIFO 1.
- count2  output  log2(DEPTH)+1  occupancy of FIFO 2.

Behaviour:

Reset:
- rst_n=0 asynchronously clears both FIFOs: pointers=0, count1=count2=0, out1_valid=out2_valid=0.
- out1/out2 read 0 during and after reset until first write.
- Reset asserted mid-transfer discards all queued words; no partial state survives.

Handshakes:
- Input accept = inp_valid & inp_ready.
- Output pop on channel k = outk_valid & outk_ready.
- inp_ready = (sel ? !full2 : !full1) | (sel ? pop2 : pop1).
  - A full FIFO that pops in the same cycle still accepts.
  - The combinational path from outk_ready to inp_ready is permitted and documented.
- inp_valid=0: sel is don't-care, no state change.

Latency and ordering:
- An accepted word appears on outk with outk_valid=1 the next cycle (latency 1, no bypass).
- Per-output order is strict FIFO. There is no ordering relation between out1 and out2.

Output stability:
- While outk_valid=1 and outk_ready=0, outk and outk_valid stay stable.

FIFO rules (each output):
- States per FIFO, derived from count: EMPTY (0), PARTIAL (0<count<DEPTH), FULL (DEPTH).
- Push only (accept, sel selects k): count+1, write at wr_ptr, wr_ptr+1 mod DEPTH.
- Pop only: count-1, rd_ptr+1 mod DEPTH.
- Push and pop same cycle: count unchanged, both pointers advance.
  - Legal in EMPTY? No: pop requires valid, so EMPTY with push -> count=1.
- Pointers are log2(DEPTH) bits and wrap naturally. count is separate to distinguish full from empty.
- Never write when FULL without a simultaneous pop; never pop when EMPTY. Both are guaranteed by the handshake equations.

Independence:
- A word for out2 is accepted while FIFO 1 is FULL and stalled.
- Only the selected FIFO's state gates inp_ready.

Throughput:
- 1 word/cycle sustained when the selected consumer holds ready high.

Decomposition:
- Shared package/header `demux_pkg`:
  - DEFAULT_WIDTH=8, DEFAULT_DEPTH=2.
  - Localparam PTR_W=$clog2(DEPTH).
  - SEL_OUT1=1'b0, SEL_OUT2=1'b1.
- One natural sub-module, `sync_fifo_reg`, instantiated twice by a generate loop over the two outputs:
  - Ports: clk, rst_n, push, wdata, pop, rdata, valid, full, count.
  - Implements the pointer/count logic.
- Top level holds only the steering/ready equations.

Test Plan:
1. Reset: rst_n=0 with inp_valid=1, inp=8'hCC -> out1_valid=out2_valid=0, count1=count2=0, inp_ready=1 after release; nothing queued.
2. Basic routing: push 8'h00 sel=0, then 8'hCC sel=1, consumers ready=1 -> out1=8'h00 valid one cycle after its accept, out2=8'hCC valid one cycle after its accept.
3. Full/backpressure: out1_ready=0, push 8'h11, 8'h22, 8'h33 all sel=0 -> first two accepted, count1=2, inp_ready=0 on third. Raise out1_ready -> pops 8'h11, 8'h33 accepted the same cycle, then order out1 = 11, 22, 33.
4. Independence: FIFO1 full and stalled, push 8'hA5 sel=1 -> accepted immediately, out2=8'hA5 next cycle, count1 stays 2.
5. Wrap-around and throughput: 10 back-to-back words 8'h01..8'h0A sel=0, out1_ready=1 -> inp_ready stays 1, out1 emits 01..0A in order on consecutive cycles, count1 never exceeds 1.
6. Reset mid-operation: both FIFOs full (8'hF0, 8'hF1 / 8'hE0, 8'hE1), pulse rst_n low between clock edges -> valids drop immediately (async); after release, first push 8'h5A sel=1 appears alone on out2.

Source files
------------

// File: rtl/demux_1x2_8bit_stream_pkg.sv
// Shared constants and helpers for the 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;
  localparam int PTR_W         = $clog2(DEFAULT_DEPTH);

  localparam logic SEL_OUT1 = 1'b0;
  localparam logic SEL_OUT2 = 1'b1;

  // Occupancy class of an output FIFO, derived purely from its count.
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_e;

  function automatic fifo_state_e fifo_state(input int count, input int depth);
    if (count == 0) begin
      return FIFO_EMPTY;
    end else if (count >= depth) begin
      return FIFO_FULL;
    end else begin
      return FIFO_PARTIAL;
    end
  endfunction

endpackage

// File: rtl/demux_1x2_8bit_stream_sync_fifo_reg.sv
// Small register-based synchronous FIFO: one output queue of the demux.
// DEPTH must be a power of two (>= 2) so the pointers wrap on their own;
// a separate count register tells full from empty.
module sync_fifo_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE = 1;
  localparam logic [PTR_BITS:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]   count_q, count_d;
  fifo_state_e         state;

  assign state = fifo_state(32'(count_q), DEPTH);
  assign valid = (state != FIFO_EMPTY);
  assign full  = (state == FIFO_FULL);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next pointers and occupancy; a simultaneous push and pop leaves count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head word reads 0 until the first write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/demux_1x2_8bit_stream.sv
// Registered 1-to-2 stream demultiplexer. Each destination has its own
// FIFO so a stalled consumer never blocks words queued for the other one.
// inp_ready depends combinationally on the selected outk_ready: a full
// FIFO that is being drained this cycle can still take a new word.
module demux_1x2_8bit_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       inp,
  input  logic                   inp_valid,
  output logic                   inp_ready,
  input  logic                   sel,
  output logic [WIDTH-1:0]       out1,
  output logic                   out1_valid,
  input  logic                   out1_ready,
  output logic [WIDTH-1:0]       out2,
  output logic                   out2_valid,
  input  logic                   out2_ready,
  output logic [$clog2(DEPTH):0] count1,
  output logic [$clog2(DEPTH):0] count2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       valid;
  logic [1:0]       full;
  logic [1:0]       out_ready;
  logic [WIDTH-1:0] rdata [2];
  logic [CNT_W-1:0] cnt   [2];
  logic             accept;

  assign out_ready = {out2_ready, out1_ready};
  assign pop       = valid & out_ready;

  // Only the destination FIFO's state gates the input.
  assign inp_ready = (sel == SEL_OUT2) ? (!full[1] || pop[1])
                                       : (!full[0] || pop[0]);
  assign accept    = inp_valid && inp_ready;

  assign push[0] = accept && (sel == SEL_OUT1);
  assign push[1] = accept && (sel == SEL_OUT2);

  for (genvar k = 0; k < 2; k++) begin : g_out
    sync_fifo_reg #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .wdata (inp),
      .pop   (pop[k]),
      .rdata (rdata[k]),
      .valid (valid[k]),
      .full  (full[k]),
      .count (cnt[k])
    );
  end

  assign out1       = rdata[0];
  assign out2       = rdata[1];
  assign out1_valid = valid[0];
  assign out2_valid = valid[1];
  assign count1     = cnt[0];
  assign count2     = cnt[1];

endmodule
